// File: rtl/exc_pipe_chain_pkg.sv
// Shared exception-code definitions for the exception pipeline chain.
// Every exception code used by exc_pipe_chain and exc_prio_sel comes from here.
package exc_pipe_chain_pkg;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_BP      = 5'd9,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12,
    EXC_NONE    = 5'd31
  } exc_code_e;

endpackage

// File: rtl/exc_pipe_chain_if.sv
// Bus bundle for exc_pipe_chain.
//   master : driver side (pipeline/CP0 model) - drives sources, stall, flush, ack
//   slave  : exc_pipe_chain side - drives exc_req, exc_code, flush_out, stage_code
interface exc_pipe_chain_if #(
  parameter int STAGES = 4,
  parameter int SRCS   = 4,
  parameter int CODE_W = 5
);
  logic [CODE_W-1:0]             exc_in_f;
  logic [STAGES*SRCS-1:0]        src_valid;
  logic [STAGES*SRCS*CODE_W-1:0] src_code;
  logic [STAGES-1:0]             stall;
  logic                          int_req;
  logic                          flush_in;
  logic                          exc_ack;
  logic                          exc_req;
  logic [CODE_W-1:0]             exc_code;
  logic                          flush_out;
  logic [STAGES*CODE_W-1:0]      stage_code;

  modport master (
    output exc_in_f, src_valid, src_code, stall, int_req, flush_in, exc_ack,
    input  exc_req, exc_code, flush_out, stage_code
  );

  modport slave (
    input  exc_in_f, src_valid, src_code, stall, int_req, flush_in, exc_ack,
    output exc_req, exc_code, flush_out, stage_code
  );
endinterface

// File: rtl/exc_pipe_chain_prio_sel.sv
// exc_prio_sel: fixed-priority pick among SRCS exception sources of one stage.
//   valid : per-source raise flags, index 0 highest priority
//   codes : per-source codes, source k at [k*CODE_W +: CODE_W]
//   code  : code of the lowest-index valid source, EXC_NONE if none raised
module exc_prio_sel
  import exc_pipe_chain_pkg::*;
#(
  parameter int SRCS   = 4,
  parameter int CODE_W = 5
) (
  input  logic [SRCS-1:0]        valid,
  input  logic [SRCS*CODE_W-1:0] codes,
  output logic [CODE_W-1:0]      code
);
  logic found;

  always_comb begin
    code  = CODE_W'(EXC_NONE);
    found = 1'b0;
    for (int unsigned k = 0; k < SRCS; k++) begin
      if (valid[k] && !found) begin
        code  = codes[k*CODE_W +: CODE_W];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/exc_pipe_chain.sv
// exc_pipe_chain: carries exception codes down the pipeline and raises a
// single pending exception to CP0 at the commit stage.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : slave side of exc_pipe_chain_if
//     exc_in_f/src_valid/src_code : code from F and per-stage source raises
//     stall/flush_in              : per-stage hold, global clear
//     int_req/exc_ack             : interrupt at commit, CP0 accept
//     exc_req/exc_code/flush_out  : pending exception, one-cycle kill pulse
//     stage_code                  : merged code per stage
module exc_pipe_chain
  import exc_pipe_chain_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int SRCS   = 4,
  parameter int CODE_W = 5
) (
  input logic             clk,
  input logic             reset,
  exc_pipe_chain_if.slave bus
);
  localparam logic [CODE_W-1:0] NO_EXC = CODE_W'(EXC_NONE);
  localparam logic [CODE_W-1:0] INT    = CODE_W'(EXC_INT);

  logic [CODE_W-1:0] q      [STAGES];
  logic [CODE_W-1:0] sel    [STAGES];
  logic [CODE_W-1:0] merged [STAGES];
  logic              req_q;
  logic [CODE_W-1:0] code_q;
  logic              flush_q;
  logic              commit;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    exc_prio_sel #(.SRCS(SRCS), .CODE_W(CODE_W)) u_sel (
      .valid (bus.src_valid[g*SRCS +: SRCS]),
      .codes (bus.src_code[g*SRCS*CODE_W +: SRCS*CODE_W]),
      .code  (sel[g])
    );
    // Held code beats any new source; everything reads as empty while a
    // request is pending so later raises cannot leak onto stage_code.
    assign merged[g] = req_q           ? NO_EXC :
                       (q[g] != NO_EXC) ? q[g]   : sel[g];
    assign bus.stage_code[g*CODE_W +: CODE_W] = merged[g];
  end

  assign commit = !req_q && ((merged[STAGES-1] != NO_EXC) || bus.int_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < STAGES; s++) q[s] <= NO_EXC;
      req_q   <= 1'b0;
      code_q  <= NO_EXC;
      flush_q <= 1'b0;
    end else begin
      flush_q <= commit;
      if (req_q) begin
        if (bus.exc_ack) begin
          req_q  <= 1'b0;
          code_q <= NO_EXC;
        end
      end else if (commit) begin
        req_q  <= 1'b1;
        code_q <= bus.int_req ? INT : merged[STAGES-1];
      end
      // The commit cycle itself clears the stages, so nothing survives into
      // the pending window to re-raise after the ack.
      if (bus.flush_in || req_q || commit) begin
        for (int unsigned s = 0; s < STAGES; s++) q[s] <= NO_EXC;
      end else begin
        if (!bus.stall[0]) q[0] <= bus.exc_in_f;
        for (int unsigned s = 1; s < STAGES; s++) begin
          if (!bus.stall[s]) q[s] <= bus.stall[s-1] ? NO_EXC : merged[s-1];
        end
      end
    end
  end

  assign bus.exc_req   = req_q;
  assign bus.exc_code  = code_q;
  assign bus.flush_out = flush_q;
endmodule

// File: doc/exc_pipe_chain.md
EXC_PIPE_CHAIN -- requirements
Module: exc_pipe_chain

Interface
REQ-001 Parameter STAGES, default 4: pipeline stages carrying an exception code; stage 0 is D, stage STAGES-1 is the commit stage.
REQ-002 Parameter SRCS, default 4: exception sources per stage; index 0 has highest priority.
REQ-003 Parameter CODE_W, default 5: exception-code width.
REQ-004 clk  in  1  the single clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 exc_in_f  in  CODE_W  code arriving from F; `No_ExcCode when F raised nothing.
REQ-007 src_valid  in  STAGES*SRCS  source raise flags; bit s*SRCS+k is source k of stage s.
REQ-008 src_code  in  STAGES*SRCS*CODE_W  codes, same indexing as src_valid.
REQ-009 stall  in  STAGES  bit s set: stage s holds its contents.
REQ-010 int_req  in  1  external interrupt request, sampled at the commit stage.
REQ-011 flush_in  in  1  external flush (e.g. eret); clears all stages.
REQ-012 exc_ack  in  1  CP0 accepts the pending exception.
REQ-013 exc_req  out  1  pending exception held for CP0.
REQ-014 exc_code  out  CODE_W  code of the pending exception; `No_ExcCode when exc_req=0.
REQ-015 flush_out  out  1  one-cycle pulse telling the pipeline to kill in-flight instructions.
REQ-016 stage_code  out  STAGES*CODE_W  merged code per stage, for observation and bypass.

Function
REQ-017 Merged code of stage s: the stored code q[s] if q[s] != `No_ExcCode; else the code of the lowest-index valid source of stage s; else `No_ExcCode.
REQ-018 The older-instruction code always wins: a held code is never overwritten by a later source.
REQ-019 Advance when stall[s]=0: q[0] <= exc_in_f, and q[s] <= merged[s-1] for s>=1.
REQ-020 When stall[s-1]=1 and stall[s]=0, stage s loads a bubble (`No_ExcCode).
REQ-021 stall is monotone: stall[s]=1 requires stall[s-1]=1; non-monotone input is unsupported and is flagged by a bench assertion.
REQ-022 Commit event: exc_req=0, and either merged[STAGES-1] != `No_ExcCode or int_req=1.
REQ-023 On a commit event: next cycle exc_req=1 and exc_code is latched; flush_out pulses high for exactly that same one cycle.
REQ-024 When int_req and a stage exception coincide, the interrupt wins and exc_code = `ExcCode_Int.
REQ-025 While exc_req=1, the block takes no further commit events and all q[s] are held at `No_ExcCode, regardless of stall.
REQ-026 exc_req stays high until exc_ack=1; it falls in the cycle after ack, and exc_code returns to `No_ExcCode.
REQ-027 exc_ack while exc_req=0 is ignored.
REQ-028 A new commit event can occur in the cycle after exc_req falls.
REQ-029 flush_in=1: all q[s] <= `No_ExcCode next cycle; this has priority over advance and stall. flush_in does not clear a pending exc_req.
REQ-030 Latency: with no stall, a source raised in stage s at cycle t appears on exc_req at cycle t+STAGES-s. Each stall cycle adds one cycle.

Reset
REQ-031 Reset in a cycle forces, in the next cycle: all q[s] = `No_ExcCode, exc_req=0, exc_code = `No_ExcCode, flush_out=0.
REQ-032 Reset overrides commit, ack, flush_in and stall in the same cycle, including reset while an exception is pending.

Structure
REQ-033 `No_ExcCode, `ExcCode_Int and all exception codes come from the shared exception-code header; no literal codes appear in the block.
REQ-034 Per-stage priority selection is one sub-module, exc_prio_sel, parametrised by SRCS and CODE_W and instantiated STAGES times.
REQ-035 Stage registers and the commit/pending logic live in exc_pipe_chain; there are no other state elements.

Verification (STAGES=4, SRCS=4)
REQ-036 Stage-1 source 2 raises `ExcCode_Ov at cycle 10, no stall -> exc_req=1 and exc_code=`ExcCode_Ov at cycle 13; flush_out is high at cycle 13 only.
REQ-037 exc_in_f=`ExcCode_AdEL and D source 0 raises `ExcCode_RI in the same instruction -> commit code is `ExcCode_AdEL.
REQ-038 stall=4'b0011 for 2 cycles during transit -> the bubble enters stage 2 and commit is delayed by 2 cycles with the code intact.
REQ-039 int_req=1 in the same cycle as a `ExcCode_Syscall commit -> exc_code=`ExcCode_Int; no second request follows for the syscall.
REQ-040 exc_req held for 5 cycles before exc_ack, with new sources raised meanwhile -> no new request, all stage_code = `No_ExcCode; a new source raised after the ack commits normally.
REQ-041 reset asserted while exc_req=1 and flush_in=1 -> next cycle all outputs are at their reset values.
